// File: rtl/debug_dump_pkg.sv
// Shared constants for the capture-buffer debug read port initiator.
package debug_dump_pkg;

    // Frame header byte at the start of every dump.
    localparam logic [7:0] DBG_SYNC = 8'hA5;

    // Address bit selecting the K-flag array instead of the data array.
    localparam int DBG_ISKBIT = 15;

    // Which array the current read targets.
    typedef enum logic {
        PH_DATA = 1'b0,
        PH_ISK  = 1'b1
    } phase_e;

endpackage

// File: rtl/debug_dump_ser.sv
// 32-bit load, 1..4 byte little-endian shifter with valid/ready output.
module debug_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    input  logic        ready_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    output logic        last_o
);

    logic [31:0] data_q;
    logic [2:0]  cnt_q;
    logic        fire;

    assign valid_o = (cnt_q != 3'd0);
    assign byte_o  = data_q[7:0];
    assign fire    = valid_o && ready_i;
    assign last_o  = fire && (cnt_q == 3'd1);

    // Load a word, then shift one byte out per accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 32'h0;
            cnt_q  <= 3'd0;
        end else if (load_i) begin
            data_q <= data_i;
            cnt_q  <= nbytes_i;
        end else if (fire) begin
            data_q <= {8'h00, data_q[31:8]};
            cnt_q  <= cnt_q - 3'd1;
        end
    end

endmodule

// File: rtl/debug_dump.sv
// Walks a range of capture-buffer words over the debug read port and
// serialises them (plus optional K-flag nibbles) into a byte stream.
module debug_dump
    import debug_dump_pkg::*;
#(
    parameter int         NSZ     = 12,
    parameter int         TIMEOUT = 64,
    parameter logic [7:0] SYNC    = DBG_SYNC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NSZ-1:0] first,
    input  logic [NSZ:0]   count,
    input  logic           with_isk,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [15:0]    debugaddr,
    output logic           debugreq,
    input  logic           debugack,
    input  logic [31:0]    debugrdata,
    output logic [7:0]     odat,
    output logic           ovalid,
    input  logic           oready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SETUP, S_REQ, S_GAP, S_SEND
    } state_e;

    state_e         state_q, state_d;
    logic [NSZ-1:0] i_q, i_d;
    logic [NSZ:0]   rem_q, rem_d;
    logic           isk_q, isk_d;
    phase_e         phase_q, phase_d;
    logic [15:0]    addr_q, addr_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           gap_q, gap_d;

    logic           ser_load, ser_valid, ser_last, ser_ready;
    logic [31:0]    ser_data;
    logic [7:0]     ser_byte;
    logic [NSZ-1:0] i_nxt;

    // Byte address of a data word, and the K-flag address of that word.
    function automatic logic [15:0] daddr(input logic [NSZ-1:0] idx);
        return 16'({idx, 2'b00});
    endfunction

    function automatic logic [15:0] kaddr(input logic [NSZ-1:0] idx);
        return (16'd1 << DBG_ISKBIT) | 16'(idx);
    endfunction

    assign i_nxt = i_q + 1'b1;

    debug_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ser_load),
        .data_i   (ser_data),
        .nbytes_i ((phase_q == PH_ISK) ? 3'd1 : 3'd4),
        .ready_i  (ser_ready),
        .byte_o   (ser_byte),
        .valid_o  (ser_valid),
        .last_o   (ser_last)
    );

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign debugaddr = addr_q;
    assign debugreq  = (state_q == S_REQ);
    assign ser_ready = oready && (state_q == S_SEND);
    assign ovalid    = (state_q == S_HDR) || ((state_q == S_SEND) && ser_valid);
    assign odat      = (state_q == S_HDR)  ? SYNC :
                       (state_q == S_SEND) ? ser_byte : 8'h00;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            rem_q   <= '0;
            isk_q   <= 1'b0;
            phase_q <= PH_DATA;
            addr_q  <= 16'h0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            tmr_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            rem_q   <= rem_d;
            isk_q   <= isk_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
        end
    end

    // Dump sequencer: header, then per word setup/request/gap/send.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        rem_d    = rem_q;
        isk_d    = isk_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        err_d    = err_q;
        done_d   = 1'b0;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        ser_load = 1'b0;
        ser_data = debugrdata;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = first;
                    rem_d   = count;
                    isk_d   = with_isk;
                    err_d   = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (oready) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = PH_DATA;
                        addr_d  = daddr(i_q);
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                // Address has been stable for this cycle; raise req next.
                tmr_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (debugack) begin
                    ser_load = 1'b1;
                    ser_data = (phase_q == PH_ISK) ? {28'h0, debugrdata[3:0]} : debugrdata;
                    gap_d    = 1'b0;
                    state_d  = S_GAP;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    ser_load = 1'b1;
                    ser_data = 32'h0;
                    err_d    = 1'b1;
                    gap_d    = 1'b0;
                    state_d  = S_GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_GAP: begin
                // Two low cycles let the target's edge detector re-arm.
                gap_d = 1'b1;
                if (gap_q) state_d = S_SEND;
            end
            S_SEND: begin
                if (ser_last) begin
                    if ((phase_q == PH_DATA) && isk_q) begin
                        phase_d = PH_ISK;
                        addr_d  = kaddr(i_q);
                        state_d = S_SETUP;
                    end else begin
                        i_d   = i_nxt;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == (NSZ+1)'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            phase_d = PH_DATA;
                            addr_d  = daddr(i_nxt);
                            state_d = S_SETUP;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_dump.sv
// Bench for debug_dump: target model, byte/address scoreboards, vector table.
module tb_debug_dump;

    localparam int NSZ = 12;
    localparam int TO  = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [NSZ-1:0] first = '0;
    logic [NSZ:0]   count = '0;
    logic           with_isk = 1'b0;
    logic           busy, done, err;
    logic [15:0]    debugaddr;
    logic           debugreq;
    logic           debugack = 1'b0;
    logic [31:0]    debugrdata = 32'h0;
    logic [7:0]     odat;
    logic           ovalid;
    logic           oready = 1'b1;

    debug_dump #(.NSZ(NSZ), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .first(first), .count(count),
        .with_isk(with_isk), .busy(busy), .done(done), .err(err),
        .debugaddr(debugaddr), .debugreq(debugreq), .debugack(debugack),
        .debugrdata(debugrdata), .odat(odat), .ovalid(ovalid), .oready(oready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NSZ-1:0] first;
        logic [NSZ:0]   count;
        logic           isk;
        logic           noack;
        logic           bp;
        logic           restart;
        logic [31:0]    dat;
        logic [31:0]    kw;
        logic           exp_err;
    } vec_t;

    logic [7:0]  byte_q[$];
    logic [15:0] addr_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic        t_noack = 1'b0;
    logic        bp_mode = 1'b0;
    logic [31:0] t_dat = 32'h0;
    logic [31:0] t_kw  = 32'h0;
    int          hcnt = 0;
    int          ocnt = 0;
    int          done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Target model: ack 3 cycles after req rise; stream sink with optional backpressure.
    always @(posedge clk) begin
        #1;
        if (debugreq) hcnt++;
        else hcnt = 0;
        if (hcnt == 3 && !t_noack) begin
            debugack   = 1'b1;
            debugrdata = debugaddr[15] ? t_kw : t_dat;
        end else begin
            debugack   = 1'b0;
            debugrdata = 32'hDEAD_BEEF;
        end
        oready = bp_mode ? ((ocnt % 4) == 0) : 1'b1;
        ocnt++;
    end

    // Monitor: stream bytes, stall stability, request addresses, gaps, timeout length.
    logic       stall_prev = 1'b0;
    logic [7:0] odat_prev = 8'h0;
    logic       req_prev = 1'b0;
    logic [15:0] addr_prev = 16'h0;
    int         hi_cnt = 0;
    int         lo_cnt = 99;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                chk("hold_valid", ovalid, 1'b1);
                chk("hold_odat", odat, odat_prev);
            end
            if (ovalid && oready) begin
                if (byte_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", odat);
                end else chk("byte", odat, byte_q.pop_front());
            end
            if (debugreq && !req_prev) begin
                if (addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_req: got %0h expected none", debugaddr);
                end else chk("addr", debugaddr, addr_q.pop_front());
                chk("setup_addr", debugaddr, addr_prev);
                if (lo_cnt < 99) chk("req_gap", (lo_cnt >= 2), 1'b1);
                hi_cnt = 0;
            end
            if (!debugreq && req_prev && t_noack) chk("timeout_len", hi_cnt, TO);
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b0);
            end
        end
        if (debugreq) begin
            hi_cnt++;
            lo_cnt = 0;
        end else if (!busy) lo_cnt = 99;
        else if (lo_cnt < 99) lo_cnt++;
        stall_prev = ovalid && !oready && !rst;
        odat_prev  = odat;
        req_prev   = debugreq;
        addr_prev  = debugaddr;
    end

    task automatic push_expect(input vec_t v);
        logic [NSZ-1:0] idx;
        byte_q.push_back(8'hA5);
        for (int k = 0; k < int'(v.count); k++) begin
            idx = v.first + NSZ'(k);
            addr_q.push_back({2'b00, idx, 2'b00});
            for (int b = 0; b < 4; b++)
                byte_q.push_back(v.noack ? 8'h00 : 8'((v.dat >> (8 * b)) & 32'hFF));
            if (v.isk) begin
                addr_q.push_back(16'h8000 | {4'h0, idx});
                byte_q.push_back(v.noack ? 8'h00 : {4'h0, v.kw[3:0]});
            end
        end
    endtask

    task automatic pulse_start(input logic [NSZ-1:0] f, input logic [NSZ:0] c, input logic k);
        @(posedge clk); #1;
        start = 1'b1; first = f; count = c; with_isk = k;
        @(posedge clk); #1;
        start = 1'b0; first = ~f; count = 13'h5; with_isk = ~k;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc;
        t_noack = v.noack; t_dat = v.dat; t_kw = v.kw; bp_mode = v.bp;
        done_cnt = 0;
        push_expect(v);
        pulse_start(v.first, v.count, v.isk);
        chk("busy_after_start", busy, 1'b1);
        chk("err_cleared", err, 1'b0);
        if (v.restart) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1; first = 12'h0; count = 13'h1; with_isk = 1'b0;
            @(posedge clk); #1 start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s done_timeout: got no done expected done", nm);
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("bytes_left", byte_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
        chk("err_end", err, v.exp_err);
        chk("busy_end", busy, 1'b0);
        byte_q.delete();
        addr_q.delete();
    endtask

    vec_t vt[6];
    vec_t vr;

    initial begin
        vt[0] = '{first: 12'd0,    count: 13'd1, isk: 1'b0, noack: 1'b0, bp: 1'b0, restart: 1'b0,
                  dat: 32'h11223344, kw: 32'h0, exp_err: 1'b0};
        vt[1] = '{first: 12'd5,    count: 13'd2, isk: 1'b1, noack: 1'b0, bp: 1'b0, restart: 1'b0,
                  dat: 32'hAABBCCDD, kw: 32'hFFFFFFF3, exp_err: 1'b0};
        vt[2] = '{first: 12'd4095, count: 13'd2, isk: 1'b0, noack: 1'b0, bp: 1'b0, restart: 1'b0,
                  dat: 32'h55667788, kw: 32'h0, exp_err: 1'b0};
        vt[3] = '{first: 12'd7,    count: 13'd1, isk: 1'b0, noack: 1'b1, bp: 1'b0, restart: 1'b0,
                  dat: 32'h99999999, kw: 32'h0, exp_err: 1'b1};
        vt[4] = '{first: 12'd100,  count: 13'd3, isk: 1'b1, noack: 1'b0, bp: 1'b1, restart: 1'b1,
                  dat: 32'h01020304, kw: 32'h0000000C, exp_err: 1'b0};
        vt[5] = '{first: 12'd9,    count: 13'd0, isk: 1'b1, noack: 1'b0, bp: 1'b0, restart: 1'b0,
                  dat: 32'h0, kw: 32'h0, exp_err: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", debugreq, 1'b0);
        chk("rst_addr", debugaddr, 16'h0);
        chk("rst_ovalid", ovalid, 1'b0);
        chk("rst_odat", odat, 8'h0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (v == 4) chk("err_sticky", err, 1'b1);
            run_vec(vt[v], $sformatf("vec%0d", v));
        end

        // Reset while a request is outstanding abandons the dump silently.
        vr = '{first: 12'd3, count: 13'd2, isk: 1'b0, noack: 1'b1, bp: 1'b0, restart: 1'b0,
               dat: 32'h0, kw: 32'h0, exp_err: 1'b0};
        t_noack = 1'b1; bp_mode = 1'b0; done_cnt = 0;
        push_expect(vr);
        pulse_start(vr.first, vr.count, vr.isk);
        for (int c = 0; c < 200 && !debugreq; c++) @(negedge clk);
        chk("req_seen", debugreq, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req", debugreq, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovalid", ovalid, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        byte_q.delete();
        addr_q.delete();
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, 0);

        run_vec(vt[1], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_dump.md
Name: debug_dump

Overview:
- Initiator for the capture buffer's debug read port (debugaddr/debugreq/debugack/debugrdata).
- On a start pulse, walks a range of captured lane words and reads each data word, plus its K-flag nibble when enabled.
- Serialises the results into a byte stream with valid/ready handshake, for the host UART/USB link.
- Lives entirely in the system clk domain, next to the capture block.

Parameters:
- NSZ, 12, log2 of capture depth in 32-bit words; must match the capture block.
- TIMEOUT, 64, clk cycles to wait for debugack before abandoning a read.
- SYNC, 8'hA5, frame header byte emitted at the start of every dump.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle pulse; begins a dump. Ignored while busy.
- first  in  NSZ  first word index; sampled on start.
- count  in  NSZ+1  number of words to dump (0..2^NSZ); sampled on start.
- with_isk  in  1  append K-flag byte per word; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- err  out  1  sticky; set on any ack timeout, cleared by accepted start.
- debugaddr  out  16  read address to the capture block.
- debugreq  out  1  read request level.
- debugack  in  1  one-cycle acknowledge.
- debugrdata  in  32  read data, valid in the ack cycle.
- odat  out  8  stream byte.
- ovalid  out  1  stream valid.
- oready  in  1  stream ready; a byte transfers when ovalid && oready.

Behaviour:
- Reset values: busy=0, done=0, err=0, debugreq=0, debugaddr=0, ovalid=0, odat=0; FSM goes to IDLE. Reset mid-dump abandons the dump silently; no done pulse.
- FSM states: IDLE, HDR, SETUP, REQ, GAP, SEND.
- IDLE: on start, latch first, count and with_isk; clear err; set word index i=first and remaining=count. Go to HDR; busy=1 from the next cycle.
- HDR: odat=SYNC, ovalid=1. On transfer: if remaining=0, go to IDLE and pulse done; else go to SETUP.
- Address encoding:
  - Data phase: debugaddr = {2'b0, i, 2'b00}, i.e. byte address of word i, zero-extended to 16 bits.
  - K phase: debugaddr = 16'h8000 | i.
- SETUP: drive debugaddr for the current phase with debugreq=0 for exactly 1 cycle, then go to REQ. The address must be stable before req rises because the target registers the memory read.
- REQ: debugreq=1 and debugaddr held.
  - On debugack: capture debugrdata into the shift register, drop req, go to GAP.
  - If TIMEOUT cycles pass without ack: set err, load 32'h0, drop req, go to GAP.
  - A late ack arriving outside REQ is ignored.
- GAP: debugreq=0 for 2 cycles minimum, so the target's synchronised edge detector re-arms. Then go to SEND.
- SEND after the data phase:
  - Emit 4 bytes, little-endian (rdata[7:0] first); one byte per transfer, ovalid held with stable odat until oready.
  - If with_isk: go to SETUP for the K phase. Otherwise the word is complete.
- SEND after the K phase: emit one byte {4'b0, rdata[3:0]}; the word is complete.
- Word complete: i = i+1 modulo 2^NSZ (wraps 2^NSZ-1 -> 0); remaining decrements.
  - remaining reaches 0: go to IDLE, pulse done the following cycle, busy=0 the same cycle as done.
  - Otherwise go to SETUP.
- ovalid is low outside HDR/SEND. Backpressure may stall indefinitely with no timeout on the stream side.
- Per-word byte count: 4, or 5 with with_isk. Total bytes = 1 + count*(4|5).

Decomposition:
- dport.vh additions:
  - DBG_SYNC = 8'hA5.
  - DBG_ISKBIT = 15.
  - Phase encodings DATA=0, ISK=1.
  - FSM state localparams stay local to the module.
- One natural sub-module: debug_ser, a 32-bit load / N-byte (1..4) little-endian shifter with valid/ready. debug_dump instantiates it for SEND.

Test Plan:
- Target model acks 3 cycles after req rise with rdata=0x11223344; start, first=0, count=1, with_isk=0, oready=1 -> bytes A5 44 33 22 11; debugaddr=0x0000; done 1 pulse; err=0.
- first=5, count=2, with_isk=1; data 0xAABBCCDD and isk 0x3 per word -> A5 DD CC BB AA 03 DD CC BB AA 03; addresses 0x0014, 0x8005, 0x0018, 0x8006; req low ≥2 cycles between requests.
- first=4095, count=2, NSZ=12 -> word addresses 0x3FFC then 0x0000 (wrap); 9 bytes total.
- Model never acks, count=1 -> req drops after 64 cycles; bytes A5 00 00 00 00; err=1 until the next start.
- oready toggled 1 cycle on / 3 off -> odat stable while ovalid && !oready; byte order unchanged.
- Assert rst during REQ -> next cycle debugreq=0, busy=0, ovalid=0; new start runs cleanly. Start while busy -> ignored. count=0 -> only A5 then done.
